// File: rtl/sgf_mult_norm_round.sv
// FP multiply back end: normalizes the raw significand product, rounds to nearest-even,
// range-checks the exponent and packs an IEEE-754 result behind a 2-stage valid/ready pipe.
module sgf_mult_norm_round #(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*SW-1:0]      sgf_prod_i,
  input  logic [EW+1:0]        exp_sum_i,
  input  logic                 sign_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [EW+SW-1:0]     result_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int PW = 2 * SW;
  localparam int XW = EW + 2;
  // One spare bit so the two possible +1 increments can never wrap the exponent.
  localparam int IW = XW + 1;
  localparam logic [IW-1:0] EXP_MAX = IW'((2 ** EW) - 1);

  logic adv1, adv2;

  logic          s1_valid;
  logic [SW-1:0] s1_mant;
  logic          s1_guard;
  logic          s1_sticky;
  logic          s1_zero;
  logic          s1_sign;
  logic [IW-1:0] s1_exp;

  logic [SW-1:0] n_mant;
  logic          n_guard;
  logic          n_sticky;
  logic [IW-1:0] n_exp;
  logic [IW-1:0] exp_ext;

  logic          rup;
  logic [SW:0]   m2;
  logic [IW-1:0] e2;
  logic [SW-2:0] frac;
  logic          n_ovf;
  logic          n_unf;
  logic [EW+SW-1:0] n_result;
  logic          unused_hidden;

  assign adv2       = ~out_valid_o | out_ready_i;
  assign adv1       = ~s1_valid | adv2;
  assign in_ready_o = adv1;

  assign exp_ext = {{(IW-XW){exp_sum_i[XW-1]}}, exp_sum_i};

  always_comb begin
    if (sgf_prod_i[PW-1]) begin
      n_mant   = sgf_prod_i[PW-1:SW];
      n_guard  = sgf_prod_i[SW-1];
      n_sticky = |sgf_prod_i[SW-2:0];
      n_exp    = exp_ext + IW'(1);
    end else begin
      n_mant   = sgf_prod_i[PW-2:SW-1];
      n_guard  = sgf_prod_i[SW-2];
      n_sticky = |sgf_prod_i[SW-3:0];
      n_exp    = exp_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_mant   <= n_mant;
        s1_guard  <= n_guard;
        s1_sticky <= n_sticky;
        s1_zero   <= (sgf_prod_i == '0);
        s1_sign   <= sign_i;
        s1_exp    <= n_exp;
      end
    end
  end

  assign rup           = s1_guard & (s1_sticky | s1_mant[0]);
  assign m2            = {1'b0, s1_mant} + (SW+1)'(rup);
  assign unused_hidden = m2[SW-1];

  // A carry out of an all-ones mantissa renormalizes to 1.0 with the exponent bumped.
  always_comb begin
    if (m2[SW]) begin
      frac = '0;
      e2   = s1_exp + IW'(1);
    end else begin
      frac = m2[SW-2:0];
      e2   = s1_exp;
    end
  end

  always_comb begin
    n_ovf    = 1'b0;
    n_unf    = 1'b0;
    n_result = {s1_sign, e2[EW-1:0], frac};
    if (s1_zero) begin
      n_result = {s1_sign, {(EW+SW-1){1'b0}}};
    end else if (!e2[IW-1] && (e2 >= EXP_MAX)) begin
      n_result = {s1_sign, {EW{1'b1}}, {(SW-1){1'b0}}};
      n_ovf    = 1'b1;
    end else if (e2[IW-1] || (e2 == '0)) begin
      n_result = {s1_sign, {(EW+SW-1){1'b0}}};
      n_unf    = 1'b1;
    end
  end

  // Outputs only move on adv2, so a stalled result and its flags stay put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (adv2) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        result_o    <= n_result;
        overflow_o  <= n_ovf;
        underflow_o <= n_unf;
      end else begin
        result_o    <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sgf_mult_norm_round.sv
// Directed bench for sgf_mult_norm_round (SW=24, EW=8): rounding, range flags,
// backpressure hold and asynchronous reset mid-stream.
module tb_sgf_mult_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] prod = '0;
  logic [9:0]  exp_sum = '0;
  logic        sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sgf_mult_norm_round #(.SW(24), .EW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sgf_prod_i  (prod),
    .exp_sum_i   (exp_sum),
    .sign_i      (sign),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Push one vector through an idle pipe and check latency, result and flags.
  task automatic run_vec(input string tag, input logic [47:0] p, input logic [9:0] e,
                         input logic s, input logic [31:0] r, input logic ov, input logic uf);
    in_valid  = 1'b1;
    prod      = p;
    exp_sum   = e;
    sign      = s;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_ovf"}, 64'(overflow), 64'(ov));
    chk({tag, "_unf"}, 64'(underflow), 64'(uf));
    @(posedge clk); #1;
  endtask

  logic [47:0] bp_p [4];
  logic [9:0]  bp_e [4];
  logic        bp_s [4];
  logic [31:0] bp_r [4];

  initial begin
    int idx_in, idx_out, stray;
    logic xfer_in, xfer_out;

    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({overflow, underflow}), 64'd0);
    #20 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_vec("one",       48'h4000_0000_0000, 10'd127, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("norm",      48'h9000_0000_0000, 10'd127, 1'b0, 32'h4010_0000, 1'b0, 1'b0);
    run_vec("tie_even",  48'h4000_0040_0000, 10'd127, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_vec("tie_odd",   48'h4000_00C0_0000, 10'd127, 1'b0, 32'h3F80_0002, 1'b0, 1'b0);
    run_vec("above_half",48'h4000_0040_0001, 10'd127, 1'b1, 32'hBF80_0001, 1'b0, 1'b0);
    run_vec("rnd_carry", 48'h7FFF_FFC0_0000, 10'd100, 1'b0, 32'h3280_0000, 1'b0, 1'b0);
    run_vec("max_norm",  48'h8000_0000_0000, 10'd253, 1'b0, 32'h7F00_0000, 1'b0, 1'b0);
    run_vec("ovf",       48'h8000_0000_0000, 10'd254, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    run_vec("ovf_carry", 48'hFFFF_FF80_0000, 10'd253, 1'b1, 32'hFF80_0000, 1'b1, 1'b0);
    run_vec("min_norm",  48'h4000_0000_0000, 10'd1,   1'b0, 32'h0080_0000, 1'b0, 1'b0);
    run_vec("unf",       48'h4000_0000_0000, 10'd0,   1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run_vec("unf_neg",   48'h8000_0000_0000, 10'h3FB, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_vec("zero",      48'h0000_0000_0000, 10'd127, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

    // Backpressure: 4 back-to-back inputs, downstream stalled for 3 cycles.
    bp_p = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h4000_00C0_0000, 48'h7FFF_FFC0_0000};
    bp_e = '{10'd127, 10'd127, 10'd127, 10'd100};
    bp_s = '{1'b0, 1'b0, 1'b0, 1'b1};
    bp_r = '{32'h3F80_0000, 32'h4010_0000, 32'h3F80_0002, 32'hB280_0000};
    idx_in  = 0;
    idx_out = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    prod = bp_p[0]; exp_sum = bp_e[0]; sign = bp_s[0];
    for (int cyc = 0; cyc < 30 && idx_out < 4; cyc++) begin
      @(negedge clk);
      xfer_in  = in_valid & in_ready;
      xfer_out = out_valid & out_ready;
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("bp_stall_ready_%0d", cyc), 64'(in_ready), 64'd0);
        chk($sformatf("bp_hold_valid_%0d", cyc), 64'(out_valid), 64'd1);
        chk($sformatf("bp_hold_result_%0d", cyc), 64'(result), 64'(bp_r[0]));
      end
      if (xfer_out) begin
        chk($sformatf("bp_result_%0d", idx_out), 64'(result), 64'(bp_r[idx_out]));
        idx_out++;
      end
      @(posedge clk); #1;
      if (xfer_in) begin
        idx_in++;
        if (idx_in < 4) begin
          prod = bp_p[idx_in]; exp_sum = bp_e[idx_in]; sign = bp_s[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc == 4) out_ready = 1'b1;
    end
    chk("bp_count", 64'(idx_out), 64'd4);
    @(posedge clk); #1;

    // Reset with both stages full and the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    prod = 48'h9000_0000_0000; exp_sum = 10'd127; sign = 1'b0;
    @(posedge clk); #1;
    prod = 48'h8000_0000_0000; exp_sum = 10'd254;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_flags", 64'({overflow, underflow}), 64'd0);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("mid_rst_stale", 64'(stray), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
